// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer driving r15 and the imem request port
// Keeps one fetch in flight and hands each word to decode, with execute redirects overriding PC+4.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] rDr15,
  output logic [31:0] wDr15,
  output logic        wEn15,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    REQ   = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4,
    DRAIN = 3'd5
  } state_t;

  state_t      state;
  logic [31:0] pc_q;

  logic [31:0] fetchAddr;
  logic [31:0] redirectPc;
  logic        redirectLive;
  logic        respAccepted;
  logic        unusedLowBits;

  assign fetchAddr    = {rDr15[31:2], 2'b00};
  assign redirectPc   = {br_target[31:2], 2'b00};
  assign unusedLowBits = ^{rDr15[1:0], br_target[1:0]};

  // Redirects only count once the PC has been initialised.
  assign redirectLive = br_valid && (state == REQ || state == WAIT ||
                                     state == HOLD || state == DRAIN);
  assign respAccepted = (state == WAIT) && imem_resp_valid && !br_valid;

  assign imem_req_valid = (state == REQ) && !br_valid;
  assign imem_req_addr  = (state == REQ) ? fetchAddr : 32'h0;

  always_comb begin
    wEn15 = 1'b0;
    wDr15 = 32'h0;
    if (state == INIT) begin
      wEn15 = 1'b1;
      wDr15 = RESET_PC;
    end else if (redirectLive) begin
      wEn15 = 1'b1;
      wDr15 = redirectPc;
    end else if (respAccepted) begin
      wEn15 = 1'b1;
      wDr15 = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc_q       <= 32'h0;
      inst_valid <= 1'b0;
      inst_data  <= 32'h0;
      inst_pc    <= 32'h0;
    end else begin
      case (state)
        IDLE: state <= INIT;
        INIT: state <= REQ;
        REQ: begin
          if (imem_req_valid && imem_req_ready) begin
            pc_q  <= fetchAddr;
            state <= WAIT;
          end
        end
        WAIT: begin
          // A redirect that meets its own response can skip the drain.
          if (br_valid) begin
            state <= imem_resp_valid ? REQ : DRAIN;
          end else if (imem_resp_valid) begin
            inst_valid <= 1'b1;
            inst_data  <= imem_resp_data;
            inst_pc    <= pc_q;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (br_valid || inst_ready) begin
            inst_valid <= 1'b0;
            state      <= REQ;
          end
        end
        DRAIN: begin
          if (imem_resp_valid) state <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value written into r15 after reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rDr15  input  32  current PC, read from register-file r15.
REQ-005 wDr15  output  32  next PC value for r15.
REQ-006 wEn15  output  1  r15 write enable; r15 takes wDr15 at the next rising edge.
REQ-007 imem_req_valid  output  1  instruction fetch request valid.
REQ-008 imem_req_addr  output  32  fetch address, word aligned.
REQ-009 imem_req_ready  input  1  memory accepts the request.
REQ-010 imem_resp_valid  input  1  response data valid, one-cycle pulse.
REQ-011 imem_resp_data  input  32  fetched instruction word.
REQ-012 br_valid  input  1  redirect request from execute, one-cycle pulse.
REQ-013 br_target  input  32  redirect PC.
REQ-014 inst_valid  output  1  instruction available to decode.
REQ-015 inst_data  output  32  instruction word.
REQ-016 inst_pc  output  32  address the instruction was fetched from.
REQ-017 inst_ready  input  1  decode accepts the instruction.

Function
REQ-018 The FSM SHALL have states IDLE, INIT, REQ, WAIT, HOLD and DRAIN.
REQ-019 IDLE: all outputs 0; the FSM SHALL go to INIT on the first edge with rst_n high.
REQ-020 INIT: wEn15=1 and wDr15=RESET_PC for exactly one cycle, then REQ.
REQ-021 REQ: imem_req_valid = !br_valid and imem_req_addr = {rDr15[31:2],2'b00}; on a handshake (valid & ready), latch the address into pc_q and go to WAIT.
REQ-022 At most one request SHALL be outstanding; imem_req_valid SHALL be 0 in every state except REQ.
REQ-023 WAIT: on imem_resp_valid, load inst_data=imem_resp_data and inst_pc=pc_q, set inst_valid next cycle, drive wEn15=1 and wDr15=pc_q+4 (mod 2^32, 0xFFFF_FFFC wraps to 0), then go to HOLD.
REQ-024 HOLD: inst_valid=1 with inst_data and inst_pc stable; on inst_ready, go to REQ and clear inst_valid the next cycle.
REQ-025 Steady-state throughput SHALL be one instruction per 3 cycles when memory responds the cycle after the request and decode is always ready.
REQ-026 br_valid in REQ, WAIT, HOLD or DRAIN: wEn15=1 and wDr15={br_target[31:2],2'b00}; the redirect SHALL take priority over any PC+4 write in the same cycle.
REQ-027 Branch in REQ: no handshake occurs; remain in REQ and fetch from the new r15 next cycle.
REQ-028 Branch in HOLD: clear inst_valid next cycle (instruction discarded even if inst_ready is 1), then go to REQ.
REQ-029 Branch in WAIT with no response that cycle: go to DRAIN; DRAIN discards the next response without asserting inst_valid or wEn15, then goes to REQ.
REQ-030 Branch in WAIT with a response the same cycle: discard the response and go directly to REQ.
REQ-031 imem_resp_valid in IDLE, INIT, REQ or HOLD SHALL be ignored.

Reset
REQ-032 While rst_n is low, the block SHALL hold state IDLE, pc_q=0, and drive 0 on inst_valid, inst_data, inst_pc, imem_req_valid, imem_req_addr, wEn15 and wDr15.
REQ-033 Assertion of rst_n mid-transaction SHALL abandon any outstanding request; a response arriving after reset SHALL be ignored under REQ-031.

Verification
REQ-034 Reset release, memory always ready, 1-cycle response, RESET_PC=0x100 -> r15=0x100, first inst_pc=0x100, r15=0x104, inst_valid every 3rd cycle.
REQ-035 inst_ready held 0 for 5 cycles in HOLD -> inst_valid, inst_data and inst_pc stable; no new imem_req_valid until acceptance.
REQ-036 br_valid with target 0x203 while in WAIT, response 2 cycles later -> response dropped, r15=0x200, next fetch address 0x200.
REQ-037 br_valid in HOLD together with inst_ready -> instruction not counted as accepted, next inst_pc equals the branch target.
REQ-038 Fetch at 0xFFFF_FFFC -> wDr15=0x0000_0000.
REQ-039 rst_n pulsed low during WAIT, stale response after release -> no inst_valid, INIT rewrites RESET_PC.
